// File: rtl/nzcv_status_unit_if.sv
// nzcv_status_unit_if
// Bus between the EXE stage and the NZCV status unit. It carries the ALU
// operands and command, the pipeline qualifiers, and the direct-write,
// save and restore controls. In the other direction it returns the flags,
// the carry-in used by the ALU, and the combinational result.
//
// Modports:
//   master - the pipeline side. It drives the operands and controls and
//            reads back flags, carry_o and result.
//   slave  - the status unit side.
//
// Parameter: WIDTH sets the operand and result width.
interface nzcv_status_unit_if #(
    parameter int WIDTH = 32
);
    logic             exe_valid;
    logic             s_bit;
    logic [3:0]       exe_cmd;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             shift_carry;
    logic             stall;
    logic             flush;
    logic             wr_en;
    logic [3:0]       wr_nzcv;
    logic             save;
    logic             restore;
    logic [3:0]       flags;
    logic             carry_o;
    logic [WIDTH-1:0] result;

    modport master (
        output exe_valid, s_bit, exe_cmd, op_a, op_b, shift_carry,
               stall, flush, wr_en, wr_nzcv, save, restore,
        input  flags, carry_o, result
    );

    modport slave (
        input  exe_valid, s_bit, exe_cmd, op_a, op_b, shift_carry,
               stall, flush, wr_en, wr_nzcv, save, restore,
        output flags, carry_o, result
    );
endinterface

// File: rtl/nzcv_status_unit.sv
// nzcv_status_unit
// Computes N, Z, C and V from the EXE-stage operands and command. It holds
// them in the architectural status register and drives them to the
// condition evaluator in decode. It also keeps a one-entry saved-status
// shadow that is used on exception entry and return.
//
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset; clears status and shadow
//   bus   - nzcv_status_unit_if.slave, which carries:
//             operands and command, s_bit, exe_valid
//             stall and flush qualifiers
//             wr_en/wr_nzcv for a direct write
//             save/restore for the shadow
//             outputs flags, carry_o and result
//
// Optional feature: define STATUS_BYPASS_EN to forward the pending status
// write combinationally onto flags and carry_o. When it is undefined,
// flags and carry_o come only from the register.
module nzcv_status_unit #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    nzcv_status_unit_if.slave   bus
);
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    logic [3:0]       status;
    logic [3:0]       shadow;
    logic [3:0]       next_status;
    logic [3:0]       alu_nzcv;
    logic [3:0]       flags_out;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] res;
    logic [WIDTH:0]   sum;
    logic             cin;
    logic             is_arith;
    logic             is_sub;
    logic             is_flag_cmd;
    logic             upd;

    // Decode the command into adder controls. Subtraction adds ~b, and the
    // carry-in supplies the +1 (SUB) or the held C (SBC). As a result, C
    // out is the ARM not-borrow.
    always_comb begin
        is_arith    = 1'b0;
        is_sub      = 1'b0;
        is_flag_cmd = 1'b1;
        cin         = 1'b0;
        case (bus.exe_cmd)
            CMD_ADD: is_arith = 1'b1;
            CMD_ADC: begin is_arith = 1'b1; cin = status[1]; end
            CMD_SUB: begin is_arith = 1'b1; is_sub = 1'b1; cin = 1'b1; end
            CMD_SBC: begin is_arith = 1'b1; is_sub = 1'b1; cin = status[1]; end
            CMD_MOV, CMD_AND, CMD_ORR, CMD_EOR, CMD_MVN: is_flag_cmd = 1'b1;
            default: is_flag_cmd = 1'b0;
        endcase
        b_eff = is_sub ? ~bus.op_b : bus.op_b;
        sum   = {1'b0, bus.op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    end

    // Select the result for the command. A code that does not set flags
    // yields zero.
    always_comb begin
        res = '0;
        case (bus.exe_cmd)
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: res = sum[WIDTH-1:0];
            CMD_AND: res = bus.op_a & bus.op_b;
            CMD_ORR: res = bus.op_a | bus.op_b;
            CMD_EOR: res = bus.op_a ^ bus.op_b;
            CMD_MOV: res = bus.op_b;
            CMD_MVN: res = ~bus.op_b;
            default: res = '0;
        endcase
    end

    // Derive the ALU flags. Logical commands take C from the shifter and
    // leave V at its held value.
    always_comb begin
        alu_nzcv[3] = res[WIDTH-1];
        alu_nzcv[2] = (res == '0);
        alu_nzcv[1] = is_arith ? sum[WIDTH] : bus.shift_carry;
        alu_nzcv[0] = is_arith ? ((bus.op_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                                  (res[WIDTH-1] != bus.op_a[WIDTH-1]))
                               : status[0];
    end

    assign upd = bus.exe_valid & bus.s_bit & is_flag_cmd & ~bus.flush & ~bus.stall;

    // The write-source priority is restore, then the direct write, then
    // the ALU. Restore and the direct write are architectural control, so
    // stall does not hold them off.
    always_comb begin
        next_status = status;
        if (bus.restore)
            next_status = shadow;
        else if (bus.wr_en)
            next_status = bus.wr_nzcv;
        else if (upd)
            next_status = alu_nzcv;
    end

    // The shadow captures the pre-edge status. If save and restore arrive
    // together, the two registers swap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status <= 4'b0000;
            shadow <= 4'b0000;
        end else begin
            status <= next_status;
            if (bus.save)
                shadow <= status;
        end
    end

`ifdef STATUS_BYPASS_EN
    assign flags_out = next_status;
`else
    assign flags_out = status;
`endif

    assign bus.flags   = flags_out;
    assign bus.carry_o = flags_out[1];
    assign bus.result  = res;
endmodule

// File: tb/tb_nzcv_status_unit.sv
// tb_nzcv_status_unit
// Directed vectors for nzcv_status_unit. Each record holds its inputs, the
// expected combinational result, and the flags expected after the edge.
module tb_nzcv_status_unit;
    localparam int WIDTH = 32;

    typedef struct {
        logic        valid;
        logic        s;
        logic [3:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic        sc;
        logic        stall;
        logic        flush;
        logic        wr;
        logic [3:0]  wv;
        logic        save;
        logic        restore;
        logic [31:0] exp_result;
        logic [3:0]  exp_flags;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_compared;
    int   n_mismatched;
    vec_t vecs[$];

    nzcv_status_unit_if #(.WIDTH(WIDTH)) bus ();

    nzcv_status_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input logic valid, input logic s, input logic [3:0] cmd,
                          input logic [31:0] a, input logic [31:0] b, input logic sc,
                          input logic stall, input logic flush, input logic wr,
                          input logic [3:0] wv, input logic save, input logic restore,
                          input logic [31:0] er, input logic [3:0] ef);
        vec_t v;
        v.valid = valid; v.s = s; v.cmd = cmd; v.a = a; v.b = b; v.sc = sc;
        v.stall = stall; v.flush = flush; v.wr = wr; v.wv = wv;
        v.save = save; v.restore = restore; v.exp_result = er; v.exp_flags = ef;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.exe_valid   = v.valid;
        bus.s_bit       = v.s;
        bus.exe_cmd     = v.cmd;
        bus.op_a        = v.a;
        bus.op_b        = v.b;
        bus.shift_carry = v.sc;
        bus.stall       = v.stall;
        bus.flush       = v.flush;
        bus.wr_en       = v.wr;
        bus.wr_nzcv     = v.wv;
        bus.save        = v.save;
        bus.restore     = v.restore;
    endtask

    task automatic applyIdle();
        vec_t v;
        v.valid = 0; v.s = 0; v.cmd = 4'b0000; v.a = '0; v.b = '0; v.sc = 0;
        v.stall = 0; v.flush = 0; v.wr = 0; v.wv = 4'b0000; v.save = 0;
        v.restore = 0; v.exp_result = '0; v.exp_flags = 4'b0000;
        applyStimulus(v);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n        = 1'b0;
        applyIdle();

        //     vld s  cmd      a             b             sc stl fl wr wv       sv rs result        flags
        addVec(1, 1, 4'b0010, 32'h7FFFFFFF, 32'h00000001, 0, 0, 0, 0, 4'b0000, 0, 0, 32'h80000000, 4'b1001);
        addVec(1, 1, 4'b0100, 32'h00000005, 32'h00000005, 0, 0, 0, 0, 4'b0000, 0, 0, 32'h00000000, 4'b0110);
        addVec(0, 0, 4'b0000, 32'h0,        32'h0,        0, 0, 0, 1, 4'b0000, 0, 0, 32'h00000000, 4'b0000);
        addVec(1, 1, 4'b0010, 32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 0, 4'b0000, 0, 0, 32'h00000000, 4'b0110);
        addVec(1, 1, 4'b0011, 32'h00000000, 32'h00000000, 0, 0, 0, 0, 4'b0000, 0, 0, 32'h00000001, 4'b0000);
        addVec(1, 0, 4'b0100, 32'h00000003, 32'h00000005, 0, 0, 0, 0, 4'b0000, 0, 0, 32'hFFFFFFFE, 4'b0000);
        addVec(1, 1, 4'b0100, 32'h00000003, 32'h00000005, 0, 0, 1, 0, 4'b0000, 0, 0, 32'hFFFFFFFE, 4'b0000);
        addVec(1, 1, 4'b0100, 32'h00000003, 32'h00000005, 0, 1, 0, 0, 4'b0000, 0, 0, 32'hFFFFFFFE, 4'b0000);
        addVec(1, 1, 4'b0100, 32'h00000003, 32'h00000005, 0, 0, 0, 0, 4'b0000, 0, 0, 32'hFFFFFFFE, 4'b1000);
        addVec(0, 0, 4'b0000, 32'h0,        32'h0,        0, 0, 0, 1, 4'b0001, 0, 0, 32'h00000000, 4'b0001);
        addVec(1, 1, 4'b0110, 32'h000000F0, 32'h0000000F, 1, 0, 0, 0, 4'b0000, 0, 0, 32'h00000000, 4'b0111);
        addVec(1, 1, 4'b0110, 32'h000000F0, 32'h0000000F, 1, 0, 0, 1, 4'b0100, 0, 0, 32'h00000000, 4'b0100);
        addVec(0, 0, 4'b0000, 32'h0,        32'h0,        0, 0, 0, 1, 4'b1010, 0, 0, 32'h00000000, 4'b1010);
        addVec(0, 0, 4'b0000, 32'h0,        32'h0,        0, 0, 0, 0, 4'b0000, 1, 0, 32'h00000000, 4'b1010);
        addVec(0, 0, 4'b0000, 32'h0,        32'h0,        0, 0, 0, 1, 4'b0001, 0, 0, 32'h00000000, 4'b0001);
        addVec(0, 0, 4'b0000, 32'h0,        32'h0,        0, 0, 0, 0, 4'b0000, 0, 1, 32'h00000000, 4'b1010);
        addVec(0, 0, 4'b0000, 32'h0,        32'h0,        0, 0, 0, 1, 4'b0101, 0, 0, 32'h00000000, 4'b0101);
        addVec(0, 0, 4'b0000, 32'h0,        32'h0,        0, 0, 0, 0, 4'b0000, 1, 1, 32'h00000000, 4'b1010);
        addVec(0, 0, 4'b0000, 32'h0,        32'h0,        0, 0, 0, 0, 4'b0000, 0, 1, 32'h00000000, 4'b0101);
        addVec(0, 0, 4'b0000, 32'h0,        32'h0,        0, 1, 0, 1, 4'b0011, 0, 0, 32'h00000000, 4'b0011);
        addVec(0, 0, 4'b0000, 32'h0,        32'h0,        0, 1, 0, 0, 4'b0000, 0, 1, 32'h00000000, 4'b0101);
        addVec(1, 1, 4'b0101, 32'h00000005, 32'h00000003, 0, 0, 0, 0, 4'b0000, 0, 0, 32'h00000001, 4'b0010);
        addVec(1, 1, 4'b0111, 32'h000000F0, 32'h0000000F, 0, 0, 0, 0, 4'b0000, 0, 0, 32'h000000FF, 4'b0000);
        addVec(1, 1, 4'b1000, 32'hFFFFFFFF, 32'h00000000, 1, 0, 0, 0, 4'b0000, 0, 0, 32'hFFFFFFFF, 4'b1010);
        addVec(1, 1, 4'b1001, 32'h00000000, 32'h00000000, 0, 0, 0, 0, 4'b0000, 0, 0, 32'hFFFFFFFF, 4'b1000);
        addVec(1, 1, 4'b0001, 32'h12345678, 32'h00000000, 1, 0, 0, 0, 4'b0000, 0, 0, 32'h00000000, 4'b0110);
        addVec(1, 1, 4'b0000, 32'h00000001, 32'h00000002, 0, 0, 0, 0, 4'b0000, 0, 0, 32'h00000000, 4'b0110);
        addVec(1, 1, 4'b0100, 32'h80000000, 32'h00000001, 0, 0, 0, 0, 4'b0000, 0, 0, 32'h7FFFFFFF, 4'b0011);

        // Reset state
        #12;
        checkOutput("reset_flags", {28'h0, bus.flags}, 32'h0);
        checkOutput("reset_carry", {31'h0, bus.carry_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d_result", i), bus.result, vecs[i].exp_result);
`ifdef STATUS_BYPASS_EN
            checkOutput($sformatf("v%0d_bypass", i), {28'h0, bus.flags}, {28'h0, vecs[i].exp_flags});
`endif
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d_flags", i), {28'h0, bus.flags}, {28'h0, vecs[i].exp_flags});
            checkOutput($sformatf("v%0d_carry", i), {31'h0, bus.carry_o}, {31'h0, vecs[i].exp_flags[1]});
        end

        // Set every flag, then assert reset mid-cycle while a save is pending
        @(negedge clk);
        applyIdle();
        bus.wr_en   = 1'b1;
        bus.wr_nzcv = 4'b1111;
        @(posedge clk);
        #1;
        checkOutput("wr_1111", {28'h0, bus.flags}, 32'hF);
        @(negedge clk);
        applyIdle();
        bus.save = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_flags", {28'h0, bus.flags}, 32'h0);
        checkOutput("async_reset_carry", {31'h0, bus.carry_o}, 32'h0);
        @(negedge clk);
        applyIdle();
        rst_n = 1'b1;
        @(negedge clk);
        bus.restore = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("shadow_cleared", {28'h0, bus.flags}, 32'h0);
        @(negedge clk);
        applyIdle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
